// File: rtl/cart_pkg.sv
// Shared types and helpers for the cartridge download engine.
package cart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StHold
  } cart_state_e;

  // HPS ioctl_index values used by the console cores.
  localparam logic [7:0] IoctlIdxBoot  = 8'd0;
  localparam logic [7:0] IoctlIdxCart  = 8'd1;
  localparam logic [7:0] IoctlIdxCart2 = 8'd2;

  // Smallest (2^k)-1 such that 2^k >= count, capped at addr_w ones. count 0 or 1 gives 0.
  function automatic logic [31:0] pow2_mask(input logic [31:0] count, input int unsigned addr_w);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < addr_w && (m + 32'd1) < count) begin
        m = {m[30:0], 1'b1};
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/rst_stretch.sv
// Stretched reset generator: reloads on request, then holds for HOLD_CYCLES more cycles.
module rst_stretch #(
  parameter int unsigned HOLD_CYCLES = 255
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req_i,
  output logic active_o,
  output logic done_o
);

  localparam int unsigned     CntW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Reload while requested, otherwise count down to zero and stop there.
  always_comb begin
    cnt_d = cnt_q;
    if (req_i) begin
      cnt_d = CntLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  assign done_o = (cnt_d == '0);

  // Output is a flop so the core reset never glitches.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q    <= CntLoad;
      active_o <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      active_o <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/cart_loader.sv
// Cartridge download engine: ioctl byte stream to cart RAM, per-slot size/mirror tracking and
// the post-download core reset.
module cart_loader
  import cart_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned NUM_SLOTS   = 2,
  parameter int unsigned IDX_BASE    = 1,
  parameter int unsigned HOLD_CYCLES = 255,
  parameter int unsigned SLOT_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        rst_req,
  input  logic                        ioctl_download,
  input  logic [7:0]                  ioctl_index,
  input  logic                        ioctl_wr,
  input  logic [24:0]                 ioctl_addr,
  input  logic [7:0]                  ioctl_dout,
  output logic                        ram_we,
  output logic [SLOT_W-1:0]           ram_slot,
  output logic [ADDR_W-1:0]           ram_a,
  output logic [7:0]                  ram_d,
  output logic                        loading,
  output logic                        core_reset,
  output logic [NUM_SLOTS-1:0]        slot_valid,
  output logic [NUM_SLOTS*ADDR_W-1:0] mirror_mask,
  output logic                        overflow
);

  localparam logic [ADDR_W:0] CntFull = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne  = {{ADDR_W{1'b0}}, 1'b1};

  cart_state_e       state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   addr_end;
  logic [31:0]       idx_off;
  logic              idx_ok, start_load, in_range, hold_req, hold_done;

  // Index decode, address range check and running image size.
  always_comb begin
    idx_off    = 32'(ioctl_index) - IDX_BASE;
    idx_ok     = (32'(ioctl_index) >= IDX_BASE) && (idx_off < NUM_SLOTS);
    start_load = ioctl_download && idx_ok && (state_q != StLoad);
    in_range   = (ioctl_addr >> ADDR_W) == 25'd0;
    // Out-of-range bytes saturate the size at the full RAM.
    addr_end   = in_range ? ({1'b0, ioctl_addr[ADDR_W-1:0]} + CntOne) : CntFull;
    count_d    = count_q;
    if (state_q == StLoad && ioctl_wr && addr_end > count_q) begin
      count_d = addr_end;
    end
    // Holding the reload through LOAD makes the hold start exactly at LOAD exit.
    hold_req = rst_req || start_load || (state_q == StLoad);
  end

  rst_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_rst_stretch (
    .clk_sys (clk_sys),
    .reset   (reset),
    .req_i   (hold_req),
    .active_o(core_reset),
    .done_o  (hold_done)
  );

  // Download FSM with the one-cycle write pipeline and per-slot results.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      count_q     <= '0;
      ram_we      <= 1'b0;
      ram_slot    <= '0;
      ram_a       <= '0;
      ram_d       <= '0;
      loading     <= 1'b0;
      slot_valid  <= '0;
      mirror_mask <= '1;
      overflow    <= 1'b0;
    end else begin
      ram_we <= 1'b0;
      if (start_load) begin
        state_q                      <= StLoad;
        slot_q                       <= SLOT_W'(idx_off);
        slot_valid[SLOT_W'(idx_off)] <= 1'b0;
        count_q                      <= '0;
        overflow                     <= 1'b0;
        loading                      <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rst_req) state_q <= StHold;
          end
          StLoad: begin
            count_q <= count_d;
            if (ioctl_wr) begin
              if (in_range) begin
                ram_we   <= 1'b1;
                ram_slot <= slot_q;
                ram_a    <= ioctl_addr[ADDR_W-1:0];
                ram_d    <= ioctl_dout;
              end else begin
                overflow <= 1'b1;
              end
            end
            // A strobe coinciding with the falling edge is already folded into count_d.
            if (!ioctl_download) begin
              state_q                                 <= StHold;
              loading                                 <= 1'b0;
              slot_valid[slot_q]                      <= (count_d != '0);
              mirror_mask[32'(slot_q)*ADDR_W +: ADDR_W] <= ADDR_W'(pow2_mask(32'(count_d), ADDR_W));
            end
          end
          StHold: begin
            if (hold_done) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader with a behavioural slot/size model.
module tb_cart_loader;

  localparam int unsigned AW   = 16;
  localparam int unsigned NS   = 2;
  localparam int unsigned HOLD = 255;

  logic        clk_sys = 1'b0;
  logic        reset, rst_req, ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_index, ioctl_dout;
  logic [24:0] ioctl_addr;
  logic        ram_we;
  logic [0:0]  ram_slot;
  logic [15:0] ram_a;
  logic [7:0]  ram_d;
  logic        loading, core_reset, overflow;
  logic [1:0]  slot_valid;
  logic [31:0] mirror_mask;

  cart_loader #(
    .ADDR_W     (AW),
    .NUM_SLOTS  (NS),
    .IDX_BASE   (1),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .rst_req       (rst_req),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ram_we        (ram_we),
    .ram_slot      (ram_slot),
    .ram_a         (ram_a),
    .ram_d         (ram_d),
    .loading       (loading),
    .core_reset    (core_reset),
    .slot_valid    (slot_valid),
    .mirror_mask   (mirror_mask),
    .overflow      (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned slot;
    int unsigned a;
    int unsigned d;
    int unsigned cyc;
  } exp_t;
  exp_t q[$];

  // Reference model state
  int unsigned m_size[NS];
  int unsigned m_mask[NS];
  bit [NS-1:0] m_valid;
  bit          m_ovf;
  bit          m_loading;
  int unsigned m_slot;

  function automatic int unsigned ref_mask(input int unsigned size);
    int unsigned p = 1;
    while (p < size) p = p * 2;
    return p - 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_size[i] = 0;
      m_mask[i] = 32'hFFFF;
    end
    m_valid   = '0;
    m_ovf     = 1'b0;
    m_loading = 1'b0;
  endtask

  task automatic finish_model();
    if (m_loading) begin
      m_valid[m_slot] = (m_size[m_slot] != 0);
      m_mask[m_slot]  = ref_mask(m_size[m_slot]);
      m_loading       = 1'b0;
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    if (idx >= 8'd1 && idx <= 8'(NS)) begin
      m_loading         = 1'b1;
      m_slot            = 32'(idx) - 1;
      m_valid[m_slot]   = 1'b0;
      m_size[m_slot]    = 0;
      m_ovf             = 1'b0;
    end
    tick();
  endtask

  task automatic drive_byte(input int unsigned a, input logic [7:0] d, input bit fall);
    int unsigned e;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    if (fall) ioctl_download = 1'b0;
    if (m_loading) begin
      if (a < (1 << AW)) q.push_back('{slot: m_slot, a: a, d: 32'(d), cyc: cyc + 1});
      else m_ovf = 1'b1;
      e = (a < (1 << AW)) ? a + 1 : (1 << AW);
      if (e > m_size[m_slot]) m_size[m_slot] = e;
    end
    if (fall) finish_model();
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    finish_model();
    tick();
  endtask

  task automatic load_range(input logic [7:0] idx, input int unsigned base, input int unsigned n);
    start_dl(idx);
    chk("loading_in_load", 32'(loading), 32'd1);
    chk("core_reset_in_load", 32'(core_reset), 32'd1);
    for (int unsigned k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      drive_byte(base + k, 8'($urandom), k == n - 1);
    end
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_slot_valid"}, 32'(slot_valid), 32'(m_valid));
    chk({tag, "_mask0"}, 32'(mirror_mask[15:0]), m_mask[0]);
    chk({tag, "_mask1"}, 32'(mirror_mask[31:16]), m_mask[1]);
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_loading"}, 32'(loading), 32'd0);
  endtask

  // Count consecutive cycles of core_reset, bounded so a stuck reset still ends.
  task automatic measure_hold(input string name, input int unsigned exp);
    int unsigned n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      if (core_reset) n++;
      else break;
    end
    chk(name, n, exp);
  endtask

  // Monitor: every ram_we must match the oldest expected write, on the expected cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got no ram_we expected a=0x%0h d=0x%0h at cycle %0d",
                 e.a, e.d, e.cyc);
      end
      if (ram_we) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_write: got ram_we a=0x%0h d=0x%0h expected none", ram_a, ram_d);
        end else begin
          e = q.pop_front();
          if (32'(ram_slot) != e.slot || 32'(ram_a) != e.a || 32'(ram_d) != e.d || cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got s=%0d a=0x%0h d=0x%0h cyc=%0d expected s=%0d a=0x%0h d=0x%0h cyc=%0d",
                     ram_slot, ram_a, ram_d, cyc, e.slot, e.a, e.d, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned cr_hi, ld_hi;
    reset = 1'b1; rst_req = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
    model_reset();

    // Reset values
    #2;
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_slot_valid", 32'(slot_valid), 32'd0);
    chk("rst_mirror_mask", mirror_mask, 32'hFFFF_FFFF);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Power-on hold
    tick();
    reset = 1'b0;
    measure_hold("hold_power_on", HOLD);
    chk("power_on_slot_valid", 32'(slot_valid), 32'd0);

    // Basic load, last byte arrives with the falling edge
    load_range(8'd1, 0, 32'h3000);
    check_results("basic");
    measure_hold("hold_after_load", HOLD);

    // Second slot with a single byte, then reset request mid-hold
    load_range(8'd2, 0, 1);
    check_results("slot1");
    repeat (50) tick();
    rst_req = 1'b1;
    repeat (10) tick();
    rst_req = 1'b0;
    measure_hold("hold_after_rst_req", HOLD);

    // Ignored index: no writes, no reset, no state change
    tick();
    start_dl(8'd7);
    cr_hi = 0;
    ld_hi = 0;
    for (int i = 0; i < 20; i++) begin
      drive_byte($urandom_range(0, 32'hFFFF), 8'($urandom), 1'b0);
      if (core_reset) cr_hi++;
      if (loading) ld_hi++;
    end
    end_dl();
    chk("ignored_core_reset", cr_hi, 0);
    chk("ignored_loading", ld_hi, 0);
    check_results("ignored");

    // Reset request from idle
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    measure_hold("hold_rst_req_idle", HOLD);

    // Overflow: byte past the RAM dropped, top byte written
    start_dl(8'd1);
    drive_byte(32'h10000, 8'($urandom), 1'b0);
    drive_byte(32'h0FFFF, 8'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) drive_byte($urandom_range(0, 255), 8'($urandom), 1'b0);
    end_dl();
    check_results("overflow");
    measure_hold("hold_after_overflow", HOLD);

    // Async reset mid-load
    start_dl(8'd2);
    for (int i = 0; i < 5; i++) drive_byte(32'(i), 8'($urandom), 1'b0);
    tick();
    #1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    model_reset();
    #1;
    chk("async_ram_we", 32'(ram_we), 32'd0);
    chk("async_ram_a", 32'(ram_a), 32'd0);
    chk("async_loading", 32'(loading), 32'd0);
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_slot_valid", 32'(slot_valid), 32'd0);
    chk("async_mirror_mask", mirror_mask, 32'hFFFF_FFFF);
    chk("async_overflow", 32'(overflow), 32'd0);
    tick();
    reset = 1'b0;
    measure_hold("hold_after_async_reset", HOLD);

    // Clean restart after reset
    load_range(8'd2, 32'h100, 40);
    check_results("restart");
    measure_hold("hold_after_restart", HOLD);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_loader.md
Name: cart_loader

Overview:
- Parametrised cartridge download engine for the console cores.
- Takes the HPS ioctl byte stream and writes it into the cartridge RAM for up to NUM_SLOTS download indexes.
- Records the loaded size per slot and derives a power-of-two mirror mask that CPU-side address decode applies.
- Generates the stretched post-download core reset that previously lived as an ad-hoc counter in the top level.

Parameters:
- ADDR_W, 16: cartridge RAM address width; max image size is 2^ADDR_W bytes.
- NUM_SLOTS, 2: number of accepted download indexes (slots).
- IDX_BASE, 1: ioctl_index value of slot 0; slot n is IDX_BASE+n.
- HOLD_CYCLES, 255: core reset hold length after download end or a reset request; must be ≥1.
- SLOT_W, $clog2(NUM_SLOTS) (min 1): slot field width.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- rst_req, in, 1: level request (status/OSD button/RESET); extends the core reset.
- ioctl_download, in, 1: download active.
- ioctl_index, in, 8: download index.
- ioctl_wr, in, 1: byte strobe.
- ioctl_addr, in, 25: byte address.
- ioctl_dout, in, 8: byte data.
- ram_we, out, 1: cartridge RAM write enable, one cycle.
- ram_slot, out, SLOT_W: target slot of the write.
- ram_a, out, ADDR_W: write address.
- ram_d, out, 8: write data.
- loading, out, 1: a download to an accepted slot is in progress.
- core_reset, out, 1: reset to the console core.
- slot_valid, out, NUM_SLOTS: slot holds a completed image.
- mirror_mask, out, NUM_SLOTS*ADDR_W: per-slot mask (2^ceil(log2 size))-1; slot n occupies bits [n*ADDR_W +: ADDR_W].
- overflow, out, 1: a byte beyond 2^ADDR_W was dropped in the current or last load.

Behaviour:
- **Reset values:** state IDLE; ram_we=0, ram_a=0, ram_d=0, ram_slot=0, loading=0, slot_valid=0, all mirror_mask bits 1, overflow=0; core_reset=1 with hold counter=HOLD_CYCLES.
- **FSM states:** IDLE, LOAD, HOLD.
- **IDLE:**
  - On ioctl_download=1 with ioctl_index in [IDX_BASE, IDX_BASE+NUM_SLOTS-1]: latch the slot, clear that slot's valid bit, clear byte count and overflow, go to LOAD.
  - ioctl_download with any other index is ignored entirely: no writes, no reset.
- **LOAD:**
  - loading=1 and core_reset=1.
  - Each ioctl_wr with ioctl_addr < 2^ADDR_W produces ram_we=1 on the next cycle, with ram_a=ioctl_addr[ADDR_W-1:0], ram_d=ioctl_dout and ram_slot=the latched slot. Latency is exactly 1 cycle.
  - byte count = max(count, ioctl_addr+1), saturating at 2^ADDR_W; width ADDR_W+1.
  - ioctl_wr with ioctl_addr ≥ 2^ADDR_W: no write, overflow set.
  - ioctl_download falling: go to HOLD, load counter=HOLD_CYCLES, set slot_valid[slot] if count≠0, and register mirror_mask[slot]=next power of two ≥ count, minus 1. count=0 gives mask 0 and valid stays 0.
  - A strobe in the same cycle as the falling edge is still written.
- **HOLD:**
  - core_reset=1; counter decrements each cycle and the FSM returns to IDLE when it reaches 0.
  - core_reset is low starting the first cycle after the counter reads 1, giving exactly HOLD_CYCLES cycles of core_reset after LOAD exit.
  - ioctl_download rising to an accepted slot during HOLD: go directly to LOAD.
- **rst_req:**
  - In any state, rst_req=1 reloads the counter to HOLD_CYCLES and forces core_reset=1.
  - From IDLE it moves to HOLD; in LOAD it does not abort the load.
  - Releasing rst_req gives HOLD_CYCLES further cycles of reset.
- **Mid-operation reset:** an async reset during LOAD abandons the load; the slot is left invalid and the FSM restarts in IDLE with the reset hold active.
- **Slot independence:** the mask and valid bit of other slots are untouched by a load.

Decomposition:
- Shared package cart_pkg holds:
  - state enum (IDLE/LOAD/HOLD);
  - function pow2_mask(count, ADDR_W) returning (next power of two ≥ count)-1;
  - the ioctl index constants used by the cores.
- Optional sub-module rst_stretch (counter + rst_req handling, parameter HOLD_CYCLES) is natural and reusable by other cores. Everything else stays flat.

Test Plan:
- **Power-on hold:** deassert reset with HOLD_CYCLES=255 -> core_reset stays 1 for exactly 255 cycles, then 0; slot_valid=0.
- **Basic load:** index 1, 0x3000 bytes to addr 0..0x2FFF -> each ram_we one cycle after ioctl_wr with matching a/d and ram_slot=0; after the falling edge slot_valid=01, mirror_mask[0]=0x3FFF, core_reset low 255 cycles later.
- **Second slot and ignored index:** index 2 with 1 byte, then index 7 download -> slot 1 mask=0x0000, valid=11; index 7 produces no ram_we and no core_reset.
- **Overflow:** ADDR_W=16, write at ioctl_addr=0x10000 and 0xFFFF -> only 0xFFFF written, overflow=1, mask=0xFFFF.
- **Reset request during HOLD:** pulse rst_req for 10 cycles mid-HOLD -> core_reset remains 1 until 255 cycles after rst_req falls.
- **Async reset mid-LOAD:** assert reset mid-LOAD -> outputs at reset values immediately (before the next edge), slot_valid[slot]=0, the next download restarts cleanly.
